// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. One result bit per clock: a shift-add
// multiply or a restoring shift-subtract divide, both working on magnitudes and
// followed by a sign fix-up. Presents a registered result with a one-cycle
// done pulse.
// Optional feature macro: MDU_FAST_SPECIAL_EN -- divide by zero, signed
// overflow and multiply by zero take a short path with busy held low.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, one bit per edge, counter 31 down to 0
// FIX   | sign correction and half/quotient/remainder select into result
// DONE  | done pulse; a new start may be accepted here
// FAST  | (fast-special build only) registering a special-case result
module mul_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CALC = 3'd1;
   localparam logic [2:0] S_FIX  = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_FAST = 3'd4;

   logic [2:0]        state;
   logic [4:0]        cnt;
   logic [2:0]        op_q;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opnd;
   logic              neg_q;
   logic              neg_r;
   logic              bz_q;

   logic              sgn_a, sgn_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              accept;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     trial;
   logic [2*XLEN-1:0] step_val;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, fix_val;

   // Operand sign flags and magnitudes for the incoming request.
   // Signed operands: a for MUL/MULH/MULHSU/DIV/REM, b for MUL/MULH/DIV/REM.
   always_comb begin
      sgn_a  = a[XLEN-1] & (op == 3'b000 || op == 3'b001 || op == 3'b010 ||
                            op == 3'b100 || op == 3'b110);
      sgn_b  = b[XLEN-1] & (op == 3'b000 || op == 3'b001 ||
                            op == 3'b100 || op == 3'b110);
      mag_a  = sgn_a ? -a : a;
      mag_b  = sgn_b ? -b : b;
      accept = start && !flush && (state == S_IDLE || state == S_DONE);
   end

   // One iteration: low half of acc holds the multiplier (MUL) or the
   // dividend shifting into quotient bits (DIV); high half accumulates.
   always_comb begin
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      trial   = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
      if (!op_q[2])
         step_val = {mul_sum, acc[XLEN-1:1]};
      else if (!trial[XLEN])
         step_val = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         step_val = {acc[2*XLEN-2:0], 1'b0};
   end

   // Sign fix-up and final select.
   always_comb begin
      prod    = neg_q ? -acc : acc;
      quo     = bz_q ? '1 : (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
      rem     = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (!op_q[2])
         fix_val = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else
         fix_val = op_q[1] ? rem : quo;
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         op_q   <= '0;
         acc    <= '0;
         opnd   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         bz_q   <= 1'b0;
         result <= '0;
      end else if (flush && state != S_IDLE) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  op_q  <= op;
                  opnd  <= op[2] ? mag_b : mag_a;
                  acc   <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
                  neg_q <= sgn_a ^ sgn_b;
                  neg_r <= sgn_a;
                  bz_q  <= (b == '0);
                  cnt   <= 5'd31;
                  state <= S_CALC;
`ifdef MDU_FAST_SPECIAL_EN
                  // Preload acc with the final magnitude pair so FIX logic
                  // produces the special result directly.
                  if (op[2] && b == '0) begin
                     acc   <= {mag_a, {XLEN{1'b1}}};
                     state <= S_FAST;
                  end else if (op[2] && !op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
                     state <= S_FAST;
                  end else if (!op[2] && (a == '0 || b == '0)) begin
                     acc   <= '0;
                     state <= S_FAST;
                  end
`endif
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CALC: begin
               acc <= step_val;
               cnt <= cnt - 5'd1;
               if (cnt == 5'd0)
                  state <= S_FIX;
            end
            S_FIX, S_FAST: begin
               result <= fix_val;
               state  <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state == S_CALC) || (state == S_FIX);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against a plain-arithmetic
// reference model of the RV32M rules.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] last_res;

`ifdef MDU_FAST_SPECIAL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   mul_div_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
      logic signed [63:0] sx, sy;
      logic [63:0]        ux, uy, p;
      logic signed [31:0] q;
      logic [31:0]        r;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      ux = {32'b0, x};
      uy = {32'b0, y};
      r  = '0;
      case (f)
         3'd0: begin p = ux * uy; r = p[31:0]; end
         3'd1: begin p = sx * sy; r = p[63:32]; end
         3'd2: begin p = sx * $signed(uy); r = p[63:32]; end
         3'd3: begin p = ux * uy; r = p[63:32]; end
         3'd4: begin
            if (y == 0) r = 32'hFFFFFFFF;
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h80000000;
            else begin q = $signed(x) / $signed(y); r = q; end
         end
         3'd5: r = (y == 0) ? 32'hFFFFFFFF : x / y;
         3'd6: begin
            if (y == 0) r = x;
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h0;
            else begin q = $signed(x) % $signed(y); r = q; end
         end
         default: r = (y == 0) ? x : x % y;
      endcase
      return r;
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] x,
                                     input logic [31:0] y);
      if (f[2])
         return (y == 0) || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF);
      return (x == 0) || (y == 0);
   endfunction

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Waits for done from just after the accepting edge; returns the number of
   // edges counted from the accepting edge inclusive.
   task automatic wait_done(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Issues one op from an idle DUT (called at posedge+1) and checks it.
   task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
      int lat, exp_lat;
      logic [31:0] exp_r;
      exp_r   = ref_model(f, x, y);
      exp_lat = (FAST && is_special(f, x, y)) ? 2 : 34;
      op = f; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      chk({tag, "_busy"}, 32'(busy), 32'(exp_lat == 34));
      wait_done(lat);
      chk({tag, "_res"}, result, exp_r);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      last_res = exp_r;
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int lat, exp_lat;
      bit seen_done;
      logic [2:0]  f;
      logic [31:0] x, y, exp_r;

      rst = 1'b1; start = 1'b1; flush = 1'b0; op = 3'd0; a = 32'd7; b = 32'd3;
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_result", result, 32'd0);
      end
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_busy", 32'(busy), 32'd0);

      run_op(3'd0, 32'd7, 32'hFFFFFFFD, "mul");
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu");
      run_op(3'd1, 32'h80000000, 32'd2, "mulh");
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
      run_op(3'd4, 32'hFFFFFFF9, 32'd2, "div");
      run_op(3'd6, 32'hFFFFFFF9, 32'd2, "rem");
      run_op(3'd5, 32'd100, 32'd7, "divu");
      run_op(3'd7, 32'd100, 32'd7, "remu");
      run_op(3'd5, 32'd5, 32'd0, "divu_z");
      run_op(3'd6, 32'd5, 32'd0, "rem_z");
      run_op(3'd4, 32'hFFFFFFFB, 32'd0, "div_z_neg");
      run_op(3'd6, 32'hFFFFFFFB, 32'd0, "rem_z_neg");
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
      run_op(3'd0, 32'd0, 32'h12345678, "mul_zero");

      // Flush mid-divide: no done, result held, then a clean restart.
      op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_done", 32'(done), 32'd0);
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen_done = 1'b1;
      end
      chk("flush_no_done", 32'(seen_done), 32'd0);
      chk("flush_res_held", result, last_res);
      run_op(3'd5, 32'd1000, 32'd3, "after_flush");

      // Flush together with start while idle drops the start.
      op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_start_idle", 32'(busy), 32'd0);

      // Start held high: back-to-back ops, operands scrambled after acceptance.
      start = 1'b1;
      for (int i = 0; i < 1200; i++) begin
         f = 3'($urandom_range(0, 7));
         x = rand_opnd();
         y = rand_opnd();
         exp_r   = ref_model(f, x, y);
         exp_lat = (FAST && is_special(f, x, y)) ? 2 : 34;
         op = f; a = x; b = y;
         @(posedge clk); #1;
         op = 3'($urandom); a = $urandom; b = $urandom;
         wait_done(lat);
         chk($sformatf("b2b%0d_op%0d_res", i, f), result, exp_r);
         chk($sformatf("b2b%0d_lat", i), 32'(lat), 32'(exp_lat));
         if (lat >= 100) break;
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk("b2b_end_done", 32'(done), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
